// File: rtl/fismos_doorbell.sv
// Multi-channel host<->core doorbell: one request/response FSM per channel, sticky err.
// Define FISMOS_DOORBELL_TIMEOUT_EN to build the per-channel REQ watchdog.

module fismos_doorbell_ch #(
  parameter int DATA_W = 32
`ifdef FISMOS_DOORBELL_TIMEOUT_EN
  ,parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hw_i,
  input  logic [DATA_W-1:0] hw_data_i,
  input  logic              ca_i,
  input  logic              cw_i,
  input  logic [DATA_W-1:0] cw_data_i,
  input  logic              ha_i,
  output logic              idle_o,
  output logic              req_o,
  output logic              act_o,
  output logic              done_o,
  output logic [DATA_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] status_o,
  output logic              tmo_o
);
  typedef enum logic [1:0] {IDLE, REQ, ACTIVE, DONE} st_e;

  st_e               st_q;
  logic [DATA_W-1:0] ctrl_q, status_q;

`ifdef FISMOS_DOORBELL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] cnt_q;
  logic             tmo_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q <= IDLE; ctrl_q <= '0; status_q <= '0; cnt_q <= '0; tmo_q <= 1'b0;
    end else begin
      case (st_q)
        IDLE:   if (hw_i) begin st_q <= REQ; ctrl_q <= hw_data_i; cnt_q <= '0; end
        // a core_ack on the expiry edge wins over the watchdog
        REQ:    if (ca_i) st_q <= ACTIVE;
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES-1)) begin
                  st_q <= DONE; status_q <= '1; tmo_q <= 1'b1;
                end else cnt_q <= cnt_q + 1'b1;
        ACTIVE: if (cw_i) begin st_q <= DONE; status_q <= cw_data_i; end
        DONE:   if (ha_i) begin st_q <= IDLE; tmo_q <= 1'b0; end
      endcase
    end
  end
  assign tmo_o = tmo_q;
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q <= IDLE; ctrl_q <= '0; status_q <= '0;
    end else begin
      case (st_q)
        IDLE:   if (hw_i) begin st_q <= REQ; ctrl_q <= hw_data_i; end
        REQ:    if (ca_i) st_q <= ACTIVE;
        ACTIVE: if (cw_i) begin st_q <= DONE; status_q <= cw_data_i; end
        DONE:   if (ha_i) st_q <= IDLE;
      endcase
    end
  end
  assign tmo_o = 1'b0;
`endif

  assign idle_o   = (st_q == IDLE);
  assign req_o    = (st_q == REQ);
  assign act_o    = (st_q == ACTIVE);
  assign done_o   = (st_q == DONE);
  assign ctrl_o   = ctrl_q;
  assign status_o = status_q;
endmodule

module fismos_doorbell #(
  parameter int  NUM_CH         = 4,
  parameter int  DATA_W         = 32,
  parameter int  TIMEOUT_CYCLES = 1024,
  localparam int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     host_we,
  input  logic [CH_W-1:0]          host_ch,
  input  logic [DATA_W-1:0]        host_wdata,
  input  logic                     host_ack,
  input  logic [CH_W-1:0]          host_ack_ch,
  input  logic                     core_ack,
  input  logic [CH_W-1:0]          core_ack_ch,
  input  logic                     core_we,
  input  logic [CH_W-1:0]          core_ch,
  input  logic [DATA_W-1:0]        core_wdata,
  output logic [NUM_CH*DATA_W-1:0] ctrl_rdata,
  output logic [NUM_CH*DATA_W-1:0] status_rdata,
  output logic [NUM_CH-1:0]        irq_to_core,
  output logic                     interrupt_to_linux,
  output logic [NUM_CH-1:0]        ch_busy,
  output logic                     err,
  input  logic                     err_clr,
  output logic [NUM_CH-1:0]        timeout
);
  localparam int NP2 = 1 << CH_W;

  if (NUM_CH < 1 || NUM_CH > 16 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("fismos_doorbell: NUM_CH must be 1..16 and TIMEOUT_CYCLES >= 2");
  end

  logic [NUM_CH-1:0] idle, req, act, done;
  // state flags widened to the full index range; out-of-range channels read as never legal
  logic [NP2-1:0]    idle_x, req_x, act_x, done_x;
  logic              ill, err_q, err_d;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    fismos_doorbell_ch #(
      .DATA_W(DATA_W)
`ifdef FISMOS_DOORBELL_TIMEOUT_EN
      ,.TIMEOUT_CYCLES(TIMEOUT_CYCLES)
`endif
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .hw_i     (host_we  && (host_ch     == CH_W'(i))),
      .hw_data_i(host_wdata),
      .ca_i     (core_ack && (core_ack_ch == CH_W'(i))),
      .cw_i     (core_we  && (core_ch     == CH_W'(i))),
      .cw_data_i(core_wdata),
      .ha_i     (host_ack && (host_ack_ch == CH_W'(i))),
      .idle_o   (idle[i]),
      .req_o    (req[i]),
      .act_o    (act[i]),
      .done_o   (done[i]),
      .ctrl_o   (ctrl_rdata[i*DATA_W +: DATA_W]),
      .status_o (status_rdata[i*DATA_W +: DATA_W]),
      .tmo_o    (timeout[i])
    );
  end

  for (genvar i = 0; i < NP2; i++) begin : g_x
    if (i < NUM_CH) begin : g_in
      assign idle_x[i] = idle[i]; assign req_x[i] = req[i];
      assign act_x[i]  = act[i];  assign done_x[i] = done[i];
    end else begin : g_out
      assign idle_x[i] = 1'b0; assign req_x[i] = 1'b0;
      assign act_x[i]  = 1'b0; assign done_x[i] = 1'b0;
    end
  end

  assign ill = (host_we  & ~idle_x[host_ch])    | (core_ack & ~req_x[core_ack_ch]) |
               (core_we  & ~act_x[core_ch])     | (host_ack & ~done_x[host_ack_ch]);
  assign err_d = (err_q & ~err_clr) | ill;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign err                = err_q;
  assign irq_to_core        = req;
  assign ch_busy            = ~idle;
  assign interrupt_to_linux = |done;
endmodule

// File: tb/tb_fismos_doorbell.sv
// Randomized + directed bench for fismos_doorbell; expected outputs come from a
// transaction-level channel model pushed to a scoreboard queue each cycle.
module tb_fismos_doorbell;
  localparam int N  = 5;
  localparam int DW = 32;
  localparam int T  = 16;
  localparam int CW = 3;

  logic clk = 1'b0, reset = 1'b1;
  logic host_we = 0, host_ack = 0, core_ack = 0, core_we = 0, err_clr = 0;
  logic [CW-1:0] host_ch = 0, host_ack_ch = 0, core_ack_ch = 0, core_ch = 0;
  logic [DW-1:0] host_wdata = 0, core_wdata = 0;
  logic [N*DW-1:0] ctrl_rdata, status_rdata;
  logic [N-1:0] irq_to_core, ch_busy, timeout;
  logic interrupt_to_linux, err;

  fismos_doorbell #(.NUM_CH(N), .DATA_W(DW), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset),
    .host_we(host_we), .host_ch(host_ch), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_ack_ch(host_ack_ch),
    .core_ack(core_ack), .core_ack_ch(core_ack_ch),
    .core_we(core_we), .core_ch(core_ch), .core_wdata(core_wdata),
    .ctrl_rdata(ctrl_rdata), .status_rdata(status_rdata),
    .irq_to_core(irq_to_core), .interrupt_to_linux(interrupt_to_linux),
    .ch_busy(ch_busy), .err(err), .err_clr(err_clr), .timeout(timeout));

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]    irq, busy, tmo;
    logic            itl, err;
    logic [N*DW-1:0] ctrl, stat;
  } exp_t;

  exp_t q[$];
  int tests = 0, fails = 0;

  // model: per-channel phase ("free", "waiting for core", "core working", "answered")
  typedef enum {FREE, WAITING, WORKING, ANSWERED} phase_e;
  phase_e        ph[N];
  logic [DW-1:0] mc[N], ms[N];
  bit            mt[N];
  int            entered[N];
  bit            me;
  int            edge_n;

  function automatic exp_t snap();
    exp_t e;
    e.irq = '0; e.busy = '0; e.tmo = '0; e.itl = 1'b0; e.err = me;
    e.ctrl = '0; e.stat = '0;
    for (int i = 0; i < N; i++) begin
      e.irq[i]  = (ph[i] == WAITING);
      e.busy[i] = (ph[i] != FREE);
      e.tmo[i]  = mt[i];
      if (ph[i] == ANSWERED) e.itl = 1'b1;
      e.ctrl[i*DW +: DW] = mc[i];
      e.stat[i*DW +: DW] = ms[i];
    end
    return e;
  endfunction

  task automatic chk(input string nm, input logic [N*DW-1:0] got, input logic [N*DW-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s @%0t got %h expected %h", nm, $time, got, exp);
    end
  endtask

  task automatic chk_all(input exp_t e);
    chk("irq_to_core", N*DW'(irq_to_core), N*DW'(e.irq));
    chk("ch_busy", N*DW'(ch_busy), N*DW'(e.busy));
    chk("timeout", N*DW'(timeout), N*DW'(e.tmo));
    chk("interrupt_to_linux", N*DW'(interrupt_to_linux), N*DW'(e.itl));
    chk("err", N*DW'(err), N*DW'(e.err));
    chk("ctrl_rdata", ctrl_rdata, e.ctrl);
    chk("status_rdata", status_rdata, e.stat);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      ph[i] = FREE; mc[i] = '0; ms[i] = '0; mt[i] = 0; entered[i] = 0;
    end
    me = 0;
  endfunction

  // one clock of stimulus; model advances by the spec rules and the result is queued
  task automatic cyc(input bit hw, input int hc, input logic [DW-1:0] wd,
                     input bit ca, input int cac, input bit cw, input int cc,
                     input logic [DW-1:0] cd, input bit ha, input int hac, input bit ec);
    phase_e np[N];
    logic [DW-1:0] nc[N], ns[N];
    bit nt[N];
    bit ill;
    @(negedge clk);
    host_we = hw; host_ch = CW'(hc); host_wdata = wd;
    core_ack = ca; core_ack_ch = CW'(cac);
    core_we = cw; core_ch = CW'(cc); core_wdata = cd;
    host_ack = ha; host_ack_ch = CW'(hac); err_clr = ec;
    np = ph; nc = mc; ns = ms; nt = mt; ill = 0;
    edge_n++;
    if (hw) begin
      if (hc < N && ph[hc] == FREE) begin np[hc] = WAITING; nc[hc] = wd; entered[hc] = edge_n; end
      else ill = 1;
    end
    if (ca) begin
      if (cac < N && ph[cac] == WAITING) np[cac] = WORKING; else ill = 1;
    end
    if (cw) begin
      if (cc < N && ph[cc] == WORKING) begin np[cc] = ANSWERED; ns[cc] = cd; end
      else ill = 1;
    end
    if (ha) begin
      if (hac < N && ph[hac] == ANSWERED) begin np[hac] = FREE; nt[hac] = 0; end
      else ill = 1;
    end
`ifdef FISMOS_DOORBELL_TIMEOUT_EN
    for (int i = 0; i < N; i++)
      if (ph[i] == WAITING && !(ca && cac == i) && edge_n - entered[i] == T) begin
        np[i] = ANSWERED; ns[i] = '1; nt[i] = 1;
      end
`endif
    ph = np; mc = nc; ms = ns; mt = nt;
    me = (me & !ec) | ill;
    q.push_back(snap());
  endtask

  task automatic nop(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // asynchronous reset between clock edges, checked immediately and again at the next edge
  task automatic do_reset();
    @(negedge clk);
    host_we = 0; core_ack = 0; core_we = 0; host_ack = 0; err_clr = 0;
    #2 reset = 1'b1;
    model_reset();
    #1 chk_all(snap());
    q.push_back(snap());
    @(negedge clk);
    reset = 1'b0;
  endtask

  // scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk_all(e);
      end
    end
  end

  initial begin
    int hc, cac, cc, hac;
    model_reset();
    edge_n = 0;
    do_reset();

    // full handshake on ch2
    cyc(1, 2, 32'hF58C_4C04, 0, 0, 0, 0, 0, 0, 0, 0);
    nop(2);
    cyc(0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0);
    nop(1);
    cyc(0, 0, 0, 0, 0, 1, 2, 32'h0000_007E, 0, 0, 0);
    nop(2);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0);
    nop(1);

    // host_we to a busy channel, then err_clr
    cyc(1, 1, 32'h1111_1111, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 32'h2222_2222, 0, 0, 0, 0, 0, 0, 0, 0);
    nop(1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // ch3 -> ACTIVE, ch1 -> DONE, then three transitions in one cycle
    cyc(1, 3, 32'h3333_0003, 1, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 3, 1, 1, 32'hABCD_0001, 0, 0, 0);
    cyc(1, 0, 32'h0000_00A0, 0, 0, 1, 3, 32'h0000_0B03, 1, 1, 0);
    nop(1);

    // out-of-range channel indices
    cyc(1, 5, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 7, 0, 0, 0, 1, 6, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // watchdog window on ch4 (stays waiting when the watchdog is not built)
    cyc(1, 4, 32'h4444_4444, 0, 0, 0, 0, 0, 0, 0, 0);
    nop(T + 2);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 0);
    nop(1);

    // async reset with ch0 ACTIVE and ch1 DONE, then reuse ch0
    do_reset();
    cyc(1, 0, 32'h0000_0C00, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 32'h0000_0C01, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 1, 32'h0000_0D01, 0, 0, 0);
    do_reset();
    cyc(1, 0, 32'h0000_0E00, 0, 0, 0, 0, 0, 0, 0, 0);
    nop(1);

    // random traffic, mostly in-range, occasional resets
    for (int k = 0; k < 3000; k++) begin
      hc  = ($urandom_range(0, 15) == 0) ? $urandom_range(N, 7) : $urandom_range(0, N-1);
      cac = ($urandom_range(0, 15) == 0) ? $urandom_range(N, 7) : $urandom_range(0, N-1);
      cc  = ($urandom_range(0, 15) == 0) ? $urandom_range(N, 7) : $urandom_range(0, N-1);
      hac = ($urandom_range(0, 15) == 0) ? $urandom_range(N, 7) : $urandom_range(0, N-1);
      if ($urandom_range(0, 599) == 0) do_reset();
      else cyc($urandom_range(0, 9) < 4, hc, $urandom, $urandom_range(0, 9) < 3, cac,
               $urandom_range(0, 9) < 4, cc, $urandom, $urandom_range(0, 9) < 4, hac,
               $urandom_range(0, 9) < 2);
    end
    nop(2);
    @(posedge clk);
    #2;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain got %0d expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
